// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and helpers for alu_mc and muldiv_iter.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOR   = 4'd5,
    OP_SLT   = 4'd6,
    OP_SLTU  = 4'd7,
    OP_SLL   = 4'd8,
    OP_SRL   = 4'd9,
    OP_SRA   = 4'd10,
    OP_RSVD  = 4'd11,
    OP_MULT  = 4'd12,
    OP_MULTU = 4'd13,
    OP_DIV   = 4'd14,
    OP_DIVU  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // Ops 12..15 are the iterative multiply/divide group.
  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return op[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle.
// Only compiled when ALU_MULDIV_EN is defined.
`ifdef ALU_MULDIV_EN
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             neg_q, neg_d, neg_rem_q, neg_rem_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, addend, quo, rem;
  logic [WIDTH:0]     add_sum, rem_sh, mul_hi_nx, div_hi_nx;
  logic [WIDTH+1:0]   trial;
  logic [WIDTH-1:0]   mul_lo_nx, div_lo_nx;
  logic [2*WIDTH-1:0] prod;

  // Magnitudes are iterated; the sign is reapplied on the final step.
  // Multiply keeps {partial product, multiplier} in acc; divide keeps {remainder, quotient}.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    dvd_d     = dvd_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    a_neg = is_signed & a[WIDTH-1];
    b_neg = is_signed & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    addend    = acc_lo_q[0] ? opnd_q : '0;
    add_sum   = acc_hi_q + {1'b0, addend};
    mul_hi_nx = {1'b0, add_sum[WIDTH:1]};
    mul_lo_nx = {add_sum[0], acc_lo_q[WIDTH-1:1]};
    prod      = {mul_hi_nx[WIDTH-1:0], mul_lo_nx};

    rem_sh    = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    trial     = {1'b0, rem_sh} - {2'b00, opnd_q};
    div_hi_nx = trial[WIDTH+1] ? rem_sh : trial[WIDTH:0];
    div_lo_nx = {acc_lo_q[WIDTH-2:0], ~trial[WIDTH+1]};
    quo       = div_lo_nx;
    rem       = div_hi_nx[WIDTH-1:0];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = is_div ? ST_DIV : ST_MUL;
          cnt_d     = '0;
          acc_hi_d  = '0;
          acc_lo_d  = is_div ? a_mag : b_mag;
          opnd_d    = is_div ? b_mag : a_mag;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dbz_d     = (b == '0);
          dvd_d     = a;
        end
      end
      ST_MUL, ST_DIV: begin
        acc_hi_d = (state_q == ST_DIV) ? div_hi_nx : mul_hi_nx;
        acc_lo_d = (state_q == ST_DIV) ? div_lo_nx : mul_lo_nx;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (state_q == ST_MUL) begin
            {hi_d, lo_d} = neg_q ? -prod : prod;
          end else if (dbz_q) begin
            hi_d = dvd_q;
            lo_d = '1;
          end else begin
            lo_d = neg_q ? -quo : quo;
            hi_d = neg_rem_q ? -rem : rem;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      dvd_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      dvd_q     <= dvd_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule
`endif

// File: rtl/alu_mc.sv
// Multi-cycle ALU: registered single-cycle ops plus optional iterative mul/div.
// Mul/div unit is present only when ALU_MULDIV_EN is defined.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] result_q, result_d, alu_res, sum, diff;
  logic             zero_q, zero_d, ovf_q, ovf_d, alu_done_q, alu_done_d;
  logic             alu_ovf, accept, alu_go;
  logic [SHW-1:0]   sh;

  assign sh = b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    sum     = a + b;
    diff    = a - b;
    case (op_e'(op))
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  alu_res = a << sh;
      OP_SRL:  alu_res = a >> sh;
      OP_SRA:  alu_res = $signed(a) >>> sh;
      default: alu_res = '0;
    endcase

    accept = start && !busy;
`ifdef ALU_MULDIV_EN
    alu_go = accept && !is_muldiv(op);
`else
    // Without the mul/div unit, ops 12..15 fall through as reserved: result 0.
    alu_go = accept;
`endif
    result_d   = alu_go ? alu_res : result_q;
    zero_d     = alu_go ? (alu_res == '0) : zero_q;
    ovf_d      = alu_go ? alu_ovf : ovf_q;
    alu_done_d = alu_go;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q   <= '0;
      zero_q     <= 1'b1;
      ovf_q      <= 1'b0;
      alu_done_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      alu_done_q <= alu_done_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;

`ifdef ALU_MULDIV_EN
  logic md_done;

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && is_muldiv(op)),
    .is_div    (op[1]),
    .is_signed (~op[0]),
    .a         (a),
    .b         (b),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (md_done)
  );

  assign done = alu_done_q | md_done;
`else
  assign hi   = '0;
  assign lo   = '0;
  assign busy = 1'b0;
  assign done = alu_done_q;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=32); mul/div scenarios follow ALU_MULDIV_EN.
module tb_alu_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   op;
  logic [W-1:0] a, b, result, hi, lo;
  logic         zero, overflow, busy, done;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_res = '0;
  logic [W-1:0] exp_hi  = '0;
  logic [W-1:0] exp_lo  = '0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
    cyc(); cyc();
    reset = 1'b0;
    checks++; if (result !== '0)    begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (zero !== 1'b1)    begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (hi !== '0 || lo !== '0) begin failures++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b/%b exp=0/0", busy, done); end
  endtask

  task automatic alu_op(input string name, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] er, input logic eo);
    logic ez;
    op = o; a = x; b = y; start = 1'b1;
    cyc();
    start = 1'b0;
    exp_res = er;
    ez = (er == 32'h0);
    checks++; if (result !== er) begin failures++; $display("FAIL %s_result got=%h exp=%h", name, result, er); end
    checks++; if (zero !== ez) begin failures++; $display("FAIL %s_zero got=%b exp=%b", name, zero, ez); end
    checks++; if (overflow !== eo) begin failures++; $display("FAIL %s_ovf got=%b exp=%b", name, overflow, eo); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL %s_done got=%b exp=1", name, done); end
    checks++; if (hi !== exp_hi || lo !== exp_lo) begin failures++; $display("FAIL %s_hilo got=%h/%h exp=%h/%h", name, hi, lo, exp_hi, exp_lo); end
  endtask

  task automatic test_alu();
    alu_op("add_ovf",  4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    alu_op("add_wrap", 4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    alu_op("sub_zero", 4'd1,  32'd5,         32'd5,         32'h0000_0000, 1'b0);
    alu_op("sub_ovf",  4'd1,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
    alu_op("and",      4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    alu_op("or",       4'd3,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0);
    alu_op("xor",      4'd4,  32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0);
    alu_op("nor",      4'd5,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    alu_op("slt",      4'd6,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
    alu_op("sltu",     4'd7,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    alu_op("sll",      4'd8,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1'b0);
    alu_op("srl",      4'd9,  32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1'b0);
    alu_op("sra",      4'd10, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0);
    alu_op("rsvd",     4'd11, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0);
    alu_op("add_last", 4'd0,  32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0);
    cyc();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL alu_done_drop got=%b exp=0", done); end
    checks++; if (result !== exp_res) begin failures++; $display("FAIL alu_hold got=%h exp=%h", result, exp_res); end
  endtask

  task automatic test_back_to_back();
    op = 4'd0; a = 32'd1; b = 32'd2; start = 1'b1;
    cyc();
    checks++; if (result !== 32'd3 || done !== 1'b1) begin failures++; $display("FAIL b2b_first got=%h/%b exp=3/1", result, done); end
    op = 4'd1; a = 32'd10; b = 32'd3;
    cyc();
    start = 1'b0;
    exp_res = 32'd7;
    checks++; if (result !== 32'd7 || done !== 1'b1) begin failures++; $display("FAIL b2b_second got=%h/%b exp=7/1", result, done); end
    cyc();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_drop got=%b exp=0", done); end
  endtask

`ifdef ALU_MULDIV_EN
  task automatic run_md(input string name, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    int n;
    op = o; a = x; b = y; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_idle(n);
    exp_hi = eh; exp_lo = el;
    checks++; if (n != W) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, n, W); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL %s_done got=%b exp=1", name, done); end
    checks++; if (hi !== eh || lo !== el) begin failures++; $display("FAIL %s_hilo got=%h/%h exp=%h/%h", name, hi, lo, eh, el); end
    checks++; if (result !== exp_res) begin failures++; $display("FAIL %s_result_held got=%h exp=%h", name, result, exp_res); end
    cyc();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s_done_drop got=%b exp=0", name, done); end
  endtask

  task automatic test_mult_ignore_start();
    int n;
    op = 4'd12; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1;
    cyc();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mult_busy_set got=%b exp=1", busy); end
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      if (n == 5) begin
        start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0; a = $urandom; b = $urandom;
      end
      cyc();
      n++;
      if (busy === 1'b1) begin
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult_done_early got=%b exp=0 at=%0d", done, n); end
      end
    end
    start = 1'b0;
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFEB;
    checks++; if (n != W) begin failures++; $display("FAIL mult_latency got=%0d exp=%0d", n, W); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL mult_done got=%b exp=1", done); end
    checks++; if (hi !== exp_hi || lo !== exp_lo) begin failures++; $display("FAIL mult_hilo got=%h/%h exp=%h/%h", hi, lo, exp_hi, exp_lo); end
    checks++; if (result !== exp_res || overflow !== 1'b0) begin failures++; $display("FAIL mult_ignored_start got=%h/%b exp=%h/0", result, overflow, exp_res); end
    cyc();
    checks++; if (done !== 1'b0 || hi !== exp_hi) begin failures++; $display("FAIL mult_after got=%b/%h exp=0/%h", done, hi, exp_hi); end
  endtask

  task automatic test_muldiv();
    test_mult_ignore_start();
    run_md("multu",    4'd13, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE);
    run_md("divu",     4'd15, 32'd100,       32'd7,         32'd2,         32'd14);
    run_md("div_neg",  4'd14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu_dbz", 4'd15, 32'd9,         32'd0,         32'd9,         32'hFFFF_FFFF);
    run_md("div_dbz",  4'd14, 32'h8000_0000, 32'd0,         32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_accept_on_done();
    int n;
    op = 4'd13; a = 32'd6; b = 32'd7; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_idle(n);
    exp_hi = 32'd0; exp_lo = 32'd42;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL aod_done got=%b/%b exp=1/0", done, busy); end
    op = 4'd0; a = 32'd1; b = 32'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    exp_res = 32'd3;
    checks++; if (result !== 32'd3 || done !== 1'b1) begin failures++; $display("FAIL aod_accept got=%h/%b exp=3/1", result, done); end
    checks++; if (hi !== exp_hi || lo !== exp_lo) begin failures++; $display("FAIL aod_hilo got=%h/%h exp=%h/%h", hi, lo, exp_hi, exp_lo); end
  endtask

  task automatic test_reset_abort();
    int done_seen;
    op = 4'd13; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (9) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_res = '0; exp_hi = '0; exp_lo = '0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (hi !== '0 || lo !== '0) begin failures++; $display("FAIL abort_hilo got=%h/%h exp=0/0", hi, lo); end
    checks++; if (done !== 1'b0 || result !== '0 || zero !== 1'b1) begin failures++; $display("FAIL abort_state got=%b/%h/%b exp=0/0/1", done, result, zero); end
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_seen); end
    alu_op("post_abort_add", 4'd0, 32'd1, 32'd2, 32'd3, 1'b0);
  endtask
`else
  task automatic test_no_muldiv();
    int busy_seen;
    op = 4'd12; a = 32'd2; b = 32'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL nomd_done got=%b exp=1", done); end
    checks++; if (result !== '0 || zero !== 1'b1) begin failures++; $display("FAIL nomd_result got=%h/%b exp=0/1", result, zero); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nomd_busy got=%b exp=0", busy); end
    checks++; if (hi !== '0 || lo !== '0) begin failures++; $display("FAIL nomd_hilo got=%h/%h exp=0/0", hi, lo); end
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (busy === 1'b1 || done === 1'b1) busy_seen++;
    end
    checks++; if (busy_seen != 0) begin failures++; $display("FAIL nomd_busy_never got=%0d exp=0", busy_seen); end
    alu_op("nomd_add",   4'd0,  32'd4, 32'd5, 32'd9, 1'b0);
    alu_op("nomd_divu",  4'd15, 32'd9, 32'd3, 32'd0, 1'b0);
    alu_op("nomd_multu", 4'd13, 32'd7, 32'd7, 32'd0, 1'b0);
  endtask
`endif

  task automatic test_reset_priority();
    op = 4'd0; a = 32'd5; b = 32'd6; start = 1'b1; reset = 1'b1;
    cyc();
    reset = 1'b0; start = 1'b0;
    exp_res = '0; exp_hi = '0; exp_lo = '0;
    checks++; if (result !== '0 || zero !== 1'b1) begin failures++; $display("FAIL rstprio_result got=%h/%b exp=0/1", result, zero); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstprio_done got=%b exp=0", done); end
    cyc();
    checks++; if (done !== 1'b0 || result !== '0) begin failures++; $display("FAIL rstprio_after got=%b/%h exp=0/0", done, result); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
`ifdef ALU_MULDIV_EN
    test_muldiv();
    test_accept_on_done();
    test_reset_abort();
`else
    test_no_muldiv();
`endif
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; legal values 8..64, even.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled with op/a/b on the rising clk edge.
REQ-005 SHALL have port op  input  4  operation code.
REQ-006 SHALL have ports a, b  input  WIDTH  operands; shifts take amount from b[$clog2(WIDTH)-1:0] and shift a.
REQ-007 SHALL have port result  output  WIDTH  registered single-cycle result.
REQ-008 SHALL have ports zero, overflow  output  1  flags: result==0; signed overflow of ADD/SUB.
REQ-009 SHALL have ports hi, lo  output  WIDTH  mul/div result registers.
REQ-010 SHALL have ports busy, done  output  1  iterative op in flight; one-cycle completion pulse.

Function
REQ-011 SHALL use op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 reserved, 12 MULT, 13 MULTU, 14 DIV, 15 DIVU.
REQ-012 SHALL, for start with op 0..11 while not busy, load result/zero/overflow at that edge; done=1 the following cycle; hi/lo unchanged.
REQ-013 SHALL produce result 0 and overflow 0 for op 11; overflow SHALL be 0 for every op except ADD/SUB.
REQ-014 SHALL produce SLT/SLTU result 1 or 0, zero-extended.
REQ-015 SHALL use FSM states IDLE, MUL, DIV; start with op 12/13 -> MUL, op 14/15 -> DIV.
REQ-016 SHALL hold busy=1 for exactly WIDTH cycles after the accepting edge, one shift-add/restoring-subtract step per cycle, then update hi/lo, pulse done=1 for one cycle and return to IDLE.
REQ-017 SHALL compute MULT/MULTU as the full 2*WIDTH product {hi,lo}, signed or unsigned.
REQ-018 SHALL compute DIV/DIVU as lo=quotient, hi=remainder; signed quotient truncates toward zero, remainder takes the dividend's sign.
REQ-019 SHALL, on divide-by-zero, give lo=all ones and hi=a, with normal WIDTH-cycle latency.
REQ-020 SHALL ignore start while busy=1; result, flags, hi and lo SHALL not change.
REQ-021 SHALL accept start in the cycle done=1 (busy already 0).
REQ-022 SHALL capture operands at acceptance; a/b changes during busy SHALL have no effect.
REQ-023 SHALL hold result, zero, overflow, hi, lo stable until the next accepted op that writes them.

Reset
REQ-024 SHALL, with reset=1 at a rising edge, force state IDLE, result=0, zero=1, overflow=0, hi=0, lo=0, busy=0, done=0.
REQ-025 SHALL abort an in-flight mul/div on reset, with no done pulse; reset SHALL take priority over start.

Configuration
REQ-026 SHALL compile the iterative mul/div unit only when ALU_MULDIV_EN is defined.
REQ-027 SHALL, without ALU_MULDIV_EN, treat ops 12..15 as op 11: result 0, done next cycle, busy never set, hi/lo held at 0.

Structure
REQ-028 SHALL place the op-code constants, FSM state encoding and WIDTH-independent localparams in shared package alu_pkg.
REQ-029 SHALL implement multiply/divide in sub-module muldiv_iter (operands, sign mode, start in; hi, lo, done out).
REQ-030 SHALL keep the single-cycle datapath inside alu_mc.

Verification (WIDTH=32, ALU_MULDIV_EN defined unless stated)
REQ-031 SHALL cover: ADD 0x7FFFFFFF+0x00000001 -> next cycle result 0x80000000, overflow=1, zero=0, done=1.
REQ-032 SHALL cover: SUB 5-5 -> result 0, zero=1; SRA 0x80000000 by b=4 -> 0xF8000000; SLTU 0xFFFFFFFF,1 -> 0.
REQ-033 SHALL cover: MULT -3*7 -> busy 32 cycles, then done, hi=0xFFFFFFFF, lo=0xFFFFFFEB; start mid-busy ignored.
REQ-034 SHALL cover: DIVU 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 9/0 -> lo=0xFFFFFFFF, hi=9.
REQ-035 SHALL cover: reset at cycle 10 of MULTU -> next cycle busy=0, hi=lo=0, no done; fresh ADD 1+2 -> 3.
REQ-036 SHALL cover: without ALU_MULDIV_EN, MULT 2*3 -> done next cycle, result=0, busy never 1, hi=lo=0.
